// File: rtl/sidebar_text_writer_if.sv
// Sidebar character RAM write port: valid/ready write bus from the text writer to the RAM/arbiter.
interface sidebar_text_writer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;

  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/sidebar_text_writer.sv
// Converts game state into ASCII and writes it into the sidebar character RAM, one shared double-dabble converter.
// Optional build macro SIDEBAR_LEADING_BLANK_EN: leading zeros of numeric fields are written as spaces.
module sidebar_text_writer #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [23:0]           username,
  input  logic [3:0]            life,
  input  logic [9:0]            score,
  input  logic [9:0]            target,
  input  logic [9:0]            speed,
  input  logic                  mode,
  input  logic                  force_refresh,
  sidebar_text_writer_if.master wr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CONV, S_WRITE, S_LIFE, S_USER, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_field, w_field_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [9:0]        r_bin, w_bin_nxt, w_load_src;
  logic [11:0]       r_bcd, w_bcd_nxt;
  logic [21:0]       w_step;
  logic [23:0]       r_username;
  logic [3:0]        r_life;
  logic [9:0]        r_score, r_target, r_speed;
  logic              r_mode, r_dirty;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic              r_busy, r_done;
  logic              w_acc, w_diff;
  logic [3:0]        w_h, w_t, w_o;

  function automatic logic [9:0] sat999(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  // One double-dabble iteration: add-3 adjust every BCD digit, then shift {bcd, bin} left.
  function automatic logic [21:0] dd_step(input logic [11:0] bcd, input logic [9:0] bin);
    logic [11:0] adj;
    for (int d = 0; d < 3; d++) begin
      adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
    end
    return {adj, bin} << 1;
  endfunction

  assign w_acc  = r_wr_en & wr.wr_ready;
  assign w_diff = ({username, life, score, target, speed, mode} !=
                   {r_username, r_life, r_score, r_target, r_speed, r_mode});
  assign w_step = dd_step(r_bcd, r_bin);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_field <= 2'd0;
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_field <= w_field_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_field_nxt = r_field;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (r_dirty) w_state_nxt = S_SNAP;
      S_SNAP: begin
        w_state_nxt = S_CONV;
        w_field_nxt = 2'd0;
        w_cnt_nxt   = 4'd0;
      end
      S_CONV: begin
        if (r_cnt == 4'd9) begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_WRITE: begin
        if (w_acc) begin
          if (r_idx != 2'd2) begin
            w_idx_nxt = r_idx + 2'd1;
          end else if (r_field == 2'd2) begin
            w_state_nxt = S_LIFE;
          end else begin
            w_state_nxt = S_CONV;
            w_field_nxt = r_field + 2'd1;
            w_cnt_nxt   = 4'd0;
          end
        end
      end
      S_LIFE: begin
        if (w_acc) begin
          w_state_nxt = S_USER;
          w_idx_nxt   = 2'd0;
        end
      end
      S_USER: begin
        if (w_acc) begin
          if (r_idx == 2'd2) w_state_nxt = S_DONE;
          else               w_idx_nxt   = r_idx + 2'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Converter load on CONV entry; SNAP loads score from the live input being captured this cycle.
  always_comb begin
    w_load_src = r_speed;
    if (r_state == S_SNAP)      w_load_src = score;
    else if (w_field_nxt == 2'd1) w_load_src = r_target;
    w_bcd_nxt = r_bcd;
    w_bin_nxt = r_bin;
    if (r_state == S_CONV) {w_bcd_nxt, w_bin_nxt} = w_step;
    if ((w_state_nxt == S_CONV) && (r_state != S_CONV)) begin
      w_bcd_nxt = 12'd0;
      w_bin_nxt = sat999(w_load_src);
    end
  end

  assign w_h = w_bcd_nxt[11:8];
  assign w_t = w_bcd_nxt[7:4];
  assign w_o = w_bcd_nxt[3:0];

  // Outputs are precomputed from the next state so the registered bus lines up with the state.
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    case (w_state_nxt)
      S_WRITE: begin
        w_wr_en_nxt = 1'b1;
        case (w_field_nxt)
          2'd0:    w_wr_addr_nxt = ADDR_W'(12'h199) + ADDR_W'(w_idx_nxt);
          2'd1:    w_wr_addr_nxt = ADDR_W'(12'h211) + ADDR_W'(w_idx_nxt);
          default: w_wr_addr_nxt = ADDR_W'(12'h238) + ADDR_W'(w_idx_nxt);
        endcase
`ifdef SIDEBAR_LEADING_BLANK_EN
        case (w_idx_nxt)
          2'd0:    w_wr_data_nxt = (w_h == 4'd0) ? 8'h20 : {4'h3, w_h};
          2'd1:    w_wr_data_nxt = ((w_h == 4'd0) && (w_t == 4'd0)) ? 8'h20 : {4'h3, w_t};
          default: w_wr_data_nxt = {4'h3, w_o};
        endcase
`else
        case (w_idx_nxt)
          2'd0:    w_wr_data_nxt = {4'h3, w_h};
          2'd1:    w_wr_data_nxt = {4'h3, w_t};
          default: w_wr_data_nxt = {4'h3, w_o};
        endcase
`endif
      end
      S_LIFE: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = ADDR_W'(12'h138);
        if (!r_mode)               w_wr_data_nxt = 8'h02;
        else if (r_life > 4'd9)    w_wr_data_nxt = 8'h39;
        else                       w_wr_data_nxt = {4'h3, r_life};
      end
      S_USER: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = ADDR_W'(12'h0E4) + ADDR_W'({w_idx_nxt, 1'b0});
        case (w_idx_nxt)
          2'd0:    w_wr_data_nxt = r_username[7:0];
          2'd1:    w_wr_data_nxt = r_username[15:8];
          default: w_wr_data_nxt = r_username[23:16];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bcd      <= 12'd0;
      r_bin      <= 10'd0;
      r_username <= 24'd0;
      r_life     <= 4'd0;
      r_score    <= 10'd0;
      r_target   <= 10'd0;
      r_speed    <= 10'd0;
      r_mode     <= 1'b0;
      r_dirty    <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_bcd     <= w_bcd_nxt;
      r_bin     <= w_bin_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
      if (r_state == S_SNAP) begin
        r_username <= username;
        r_life     <= life;
        r_score    <= score;
        r_target   <= target;
        r_speed    <= speed;
        r_mode     <= mode;
        r_dirty    <= force_refresh;
      end else if (force_refresh || w_diff) begin
        r_dirty <= 1'b1;
      end
    end
  end

  assign wr.wr_en   = r_wr_en;
  assign wr.wr_addr = r_wr_addr;
  assign wr.wr_data = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_sidebar_text_writer.sv
// Scoreboard bench for sidebar_text_writer: directed passes, expected writes queued, monitor pops on each accepted write.
module tb_sidebar_text_writer;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic [23:0] username;
  logic [3:0]  life;
  logic [9:0]  score, target, speed;
  logic        mode, force_refresh;
  logic        busy, done;
  logic        ready_req, tog_en;
  wr_t         exp_q[$];
  int          n_chk = 0, n_err = 0;
  int          n_busy = 0, n_stall = 0;
  int          first_wr, done_at;
  logic        stalled = 1'b0;
  wr_t         held;
  string       s_spd, s_005, s_006, s_007, s_050;

  sidebar_text_writer_if #(.ADDR_W(12)) wr_if ();

  sidebar_text_writer #(.ADDR_W(12)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .username      (username),
    .life          (life),
    .score         (score),
    .target        (target),
    .speed         (speed),
    .mode          (mode),
    .force_refresh (force_refresh),
    .wr            (wr_if),
    .busy          (busy),
    .done          (done)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_pass(input string s, input string t, input string p,
                           input logic [7:0] life_ch, input logic [23:0] user);
    for (int i = 0; i < 3; i++) push_wr(12'h199 + 12'(i), s[i]);
    for (int i = 0; i < 3; i++) push_wr(12'h211 + 12'(i), t[i]);
    for (int i = 0; i < 3; i++) push_wr(12'h238 + 12'(i), p[i]);
    push_wr(12'h138, life_ch);
    push_wr(12'h0E4, user[7:0]);
    push_wr(12'h0E6, user[15:8]);
    push_wr(12'h0E8, user[23:16]);
  endtask

  // Counts cycles from the current edge; reports first write and done cycle numbers.
  task automatic run_pass(output int fw, output int da);
    fw = -1;
    da = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (fw < 0 && wr_if.wr_en) fw = c;
      if (done) begin
        da = c;
        break;
      end
    end
    if (da < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL pass_timeout: done not seen within 400 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   32'(wr_if.wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_if.wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_if.wr_data), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
  endtask

  // Sole driver of wr_ready: either follows the request or toggles every cycle.
  initial begin
    wr_if.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      wr_if.wr_ready = tog_en ? ~wr_if.wr_ready : ready_req;
    end
  end

  // Monitor: accepted writes are popped from the scoreboard; stalled writes must hold.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        stalled = 1'b0;
      end else begin
        if (busy) n_busy++;
        if (done) check("busy_at_done", 32'(busy), 32'd0);
        if (stalled) begin
          check("hold_en",   32'(wr_if.wr_en), 32'd1);
          check("hold_addr", 32'(wr_if.wr_addr), 32'(held.addr));
          check("hold_data", 32'(wr_if.wr_data), 32'(held.data));
        end
        stalled = 1'b0;
        if (wr_if.wr_en) begin
          if (wr_if.wr_ready) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_err++;
              $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                       wr_if.wr_addr, wr_if.wr_data);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
              check("wr_data", 32'(wr_if.wr_data), 32'(e.data));
            end
          end else begin
            n_stall++;
            stalled   = 1'b1;
            held.addr = wr_if.wr_addr;
            held.data = wr_if.wr_data;
          end
        end
      end
    end
  end

  initial begin
`ifdef SIDEBAR_LEADING_BLANK_EN
    s_spd = " 40"; s_005 = "  5"; s_006 = "  6"; s_007 = "  7"; s_050 = " 50";
`else
    s_spd = "040"; s_005 = "005"; s_006 = "006"; s_007 = "007"; s_050 = "050";
`endif
    clrn = 1'b0; ready_req = 1'b1; tog_en = 1'b0; force_refresh = 1'b0;
    score = 10'd123; target = 10'd500; speed = 10'd40; life = 4'd3; mode = 1'b1;
    username = {8'h41, 8'h43, 8'h42};

    // Reset values, then the reset-triggered full pass.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    push_pass("123", "500", s_spd, 8'h33, username);
    n_busy = 0;
    clrn = 1'b1;
    run_pass(first_wr, done_at);
    check("a_first_wr_cycle", 32'(first_wr), 32'd12);
    check("a_done_cycle", 32'(done_at), 32'd45);
    check("a_busy_cycles", 32'(n_busy), 32'd44);
    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Saturation and endless-mode life glyph; change-to-write latency from IDLE.
    score = 10'd1023; mode = 1'b0; life = 4'd5;
    push_pass("999", "500", s_spd, 8'h02, username);
    run_pass(first_wr, done_at);
    check("b_first_wr_cycle", 32'(first_wr), 32'd13);
    check("b_done_cycle", 32'(done_at), 32'd46);
    repeat (3) @(posedge clk);
    #1;

    // Survival life clamp with wr_ready toggling every cycle.
    mode = 1'b1; life = 4'd12;
    push_pass("999", "500", s_spd, 8'h39, username);
    n_busy = 0; n_stall = 0; tog_en = 1'b1;
    run_pass(first_wr, done_at);
    tog_en = 1'b0;
    check("c_stalls_seen", 32'(n_stall > 0), 32'd1);
    check("c_busy_len", 32'(n_busy), 32'(44 + n_stall));
    repeat (3) @(posedge clk);
    #1;

    // Score 5, then a forced pass during which score moves to 6 mid target conversion.
    score = 10'd5;
    push_pass(s_005, "500", s_spd, 8'h39, username);
    run_pass(first_wr, done_at);
    repeat (3) @(posedge clk);
    #1;
    push_pass(s_005, "500", s_spd, 8'h39, username);
    push_pass(s_006, "500", s_spd, 8'h39, username);
    force_refresh = 1'b1;
    fork
      run_pass(first_wr, done_at);
      begin
        @(posedge clk);
        #1 force_refresh = 1'b0;
        repeat (20) @(posedge clk);
        #1 score = 10'd6;
      end
    join
    check("d_first_done", 32'(done_at), 32'd46);
    run_pass(first_wr, done_at);
    check("d_second_first_wr", 32'(first_wr), 32'd13);
    check("d_second_done", 32'(done_at), 32'd46);
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted while the speed write is stalled.
    push_wr(12'h199, s_006[0]); push_wr(12'h19A, s_006[1]); push_wr(12'h19B, s_006[2]);
    push_wr(12'h211, 8'h35);    push_wr(12'h212, 8'h30);    push_wr(12'h213, 8'h30);
    force_refresh = 1'b1;
    @(posedge clk);
    #1 force_refresh = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        if (wr_if.wr_en && wr_if.wr_ready && wr_if.wr_addr == 12'h213) seen = 1'b1;
      end
      check("e_target_end_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1 ready_req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        if (wr_if.wr_en && wr_if.wr_addr == 12'h238) seen = 1'b1;
      end
      check("e_speed_stall_seen", 32'(seen), 32'd1);
    end
    repeat (2) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("e_queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    ready_req = 1'b1;
    push_pass(s_006, "500", s_spd, 8'h39, username);
    clrn = 1'b1;
    run_pass(first_wr, done_at);
    check("e_restart_done", 32'(done_at), 32'd45);
    repeat (3) @(posedge clk);
    #1;

    // Leading-zero handling for one- and two-digit scores.
    score = 10'd7;
    push_pass(s_007, "500", s_spd, 8'h39, username);
    run_pass(first_wr, done_at);
    repeat (2) @(posedge clk);
    #1;
    score = 10'd50;
    push_pass(s_050, "500", s_spd, 8'h39, username);
    run_pass(first_wr, done_at);
    repeat (5) @(posedge clk);
    #1;

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
